// File: rtl/pipeline_stage_buf.sv
// Elastic valid/ready pipeline register between CPU stages: one entry (pass-through ready)
// or a two-entry skid buffer (registered ready), with flush and saturating perf counters.
module pipeline_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int CNTW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       count,
    output logic [CNTW-1:0]  stall_cnt,
    output logic [CNTW-1:0]  squash_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNTW-1:0]  stall_q, stall_d;
    logic [CNTW-1:0]  squash_q, squash_d;
    logic             push, pop;
    logic [CNTW:0]    squash_sum;

    assign out_valid  = (count_q != 2'd0) && !flush;
    assign out_data   = head_q;
    assign count      = count_q;
    assign stall_cnt  = stall_q;
    assign squash_cnt = squash_q;

    // The skid variant must never look at out_ready, so upstream timing stays isolated.
    generate
        if (DEPTH == 1) begin : g_single
            assign in_ready = !flush && ((count_q == 2'd0) || out_ready);
        end else begin : g_skid
            assign in_ready = !flush && (count_q < 2'd2);
        end
    endgenerate

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign squash_sum = {1'b0, squash_q} + (CNTW+1)'(count_q);

    always_comb begin
        count_d  = count_q;
        head_d   = head_q;
        skid_d   = skid_q;
        stall_d  = stall_q;
        squash_d = squash_q;
        if (flush) begin
            // Data registers are deliberately left alone; only occupancy is dropped.
            count_d  = 2'd0;
            squash_d = squash_sum[CNTW] ? CNT_MAX : squash_sum[CNTW-1:0];
        end else begin
            if (out_valid && !out_ready && (stall_q != CNT_MAX))
                stall_d = stall_q + CNTW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (DEPTH == 1) begin
                if (push)
                    head_d = in_data;
            end else begin
                if (pop && (count_q == 2'd2))
                    head_d = skid_q;
                // A push only happens with count 0 or 1 here.
                if (push) begin
                    if ((count_q == 2'd0) || pop)
                        head_d = in_data;
                    else
                        skid_d = in_data;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q  <= 2'd0;
            head_q   <= '0;
            skid_q   <= '0;
            stall_q  <= '0;
            squash_q <= '0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
            stall_q  <= stall_d;
            squash_q <= squash_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_buf.sv
// Bench for pipeline_stage_buf: DEPTH=1, DEPTH=2 and DEPTH=2/CNTW=3 instances against a queue model.
module tb_pipeline_stage_buf;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        nRST;
    logic        iv1, ordy1, fl1, iv2, ordy2, fl2;
    logic [31:0] din1, din2;
    logic        ir1, ov1, ir2, ov2, ir3, ov3;
    logic [31:0] od1, od2, od3;
    logic [1:0]  cnt1, cnt2, cnt3;
    logic [15:0] stl1, sqh1, stl2, sqh2;
    logic [2:0]  stl3, sqh3;

    pipeline_stage_buf #(.WIDTH(32), .DEPTH(1), .CNTW(16)) u_d1 (
        .CLK(CLK), .nRST(nRST), .in_valid(iv1), .in_ready(ir1), .in_data(din1),
        .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .flush(fl1),
        .count(cnt1), .stall_cnt(stl1), .squash_cnt(sqh1));

    pipeline_stage_buf #(.WIDTH(32), .DEPTH(2), .CNTW(16)) u_d2 (
        .CLK(CLK), .nRST(nRST), .in_valid(iv2), .in_ready(ir2), .in_data(din2),
        .out_valid(ov2), .out_ready(ordy2), .out_data(od2), .flush(fl2),
        .count(cnt2), .stall_cnt(stl2), .squash_cnt(sqh2));

    pipeline_stage_buf #(.WIDTH(32), .DEPTH(2), .CNTW(3)) u_d3 (
        .CLK(CLK), .nRST(nRST), .in_valid(iv2), .in_ready(ir3), .in_data(din2),
        .out_valid(ov3), .out_ready(ordy2), .out_data(od3), .flush(fl2),
        .count(cnt3), .stall_cnt(stl3), .squash_cnt(sqh3));

    int checks = 0;
    int errors = 0;

    // Scoreboard state: accepted bundles in order, head register value, counters.
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] hd1 = '0, hd2 = '0;
    int st1 = 0, st2 = 0, sq1 = 0, sq2 = 0;

    typedef struct {
        logic        rn, iv;
        logic [31:0] dat;
        logic        ordy, fl;
        logic        e_ir, e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_cnt;
        int          e_stl, e_sq;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Called just after a negedge with inputs set; checks all DUTs, advances one edge.
    task automatic step();
        logic e_ir1, e_ov1, e_ir2, e_ov2;
        #1;
        e_ir1 = !fl1 && ((q1.size() == 0) || ordy1);
        e_ov1 = (q1.size() != 0) && !fl1;
        e_ir2 = !fl2 && (q2.size() < 2);
        e_ov2 = (q2.size() != 0) && !fl2;
        chk("d1.in_ready",   32'(ir1),  32'(e_ir1));
        chk("d1.out_valid",  32'(ov1),  32'(e_ov1));
        chk("d1.out_data",   od1,       hd1);
        chk("d1.count",      32'(cnt1), 32'(q1.size()));
        chk("d1.stall_cnt",  32'(stl1), 32'(sat(st1, 65535)));
        chk("d1.squash_cnt", 32'(sqh1), 32'(sat(sq1, 65535)));
        chk("d2.in_ready",   32'(ir2),  32'(e_ir2));
        chk("d2.out_valid",  32'(ov2),  32'(e_ov2));
        chk("d2.out_data",   od2,       hd2);
        chk("d2.count",      32'(cnt2), 32'(q2.size()));
        chk("d2.stall_cnt",  32'(stl2), 32'(sat(st2, 65535)));
        chk("d2.squash_cnt", 32'(sqh2), 32'(sat(sq2, 65535)));
        chk("d3.in_ready",   32'(ir3),  32'(e_ir2));
        chk("d3.out_valid",  32'(ov3),  32'(e_ov2));
        chk("d3.out_data",   od3,       hd2);
        chk("d3.count",      32'(cnt3), 32'(q2.size()));
        chk("d3.stall_cnt",  32'(stl3), 32'(sat(st2, 7)));
        chk("d3.squash_cnt", 32'(sqh3), 32'(sat(sq2, 7)));
        @(posedge CLK);
        if (!nRST) begin
            q1.delete(); hd1 = '0; st1 = 0; sq1 = 0;
            q2.delete(); hd2 = '0; st2 = 0; sq2 = 0;
        end else begin
            if (fl1) begin
                sq1 += q1.size(); q1.delete();
            end else begin
                if (e_ov1 && !ordy1) st1++;
                if (e_ov1 && ordy1) void'(q1.pop_front());
                if (e_ir1 && iv1) q1.push_back(din1);
            end
            if (fl2) begin
                sq2 += q2.size(); q2.delete();
            end else begin
                if (e_ov2 && !ordy2) st2++;
                if (e_ov2 && ordy2) void'(q2.pop_front());
                if (e_ir2 && iv2) q2.push_back(din2);
            end
        end
        if (q1.size() != 0) hd1 = q1[0];
        if (q2.size() != 0) hd2 = q2[0];
        @(negedge CLK);
    endtask

    initial begin
        //          rn iv dat       ordy fl  ir ov od        cnt stl sq
        tbl[0]  = '{1, 1, 32'hA,    0,   0,  1, 0, 32'h8,    0,  0,  0};
        tbl[1]  = '{1, 1, 32'hB,    0,   0,  1, 1, 32'hA,    1,  0,  0};
        tbl[2]  = '{1, 1, 32'hC,    0,   0,  0, 1, 32'hA,    2,  1,  0};
        tbl[3]  = '{1, 1, 32'hC,    0,   0,  0, 1, 32'hA,    2,  2,  0};
        tbl[4]  = '{1, 1, 32'hC,    1,   0,  0, 1, 32'hA,    2,  3,  0};
        tbl[5]  = '{1, 1, 32'hC,    1,   0,  1, 1, 32'hB,    1,  3,  0};
        tbl[6]  = '{1, 0, 32'h0,    1,   0,  1, 1, 32'hC,    1,  3,  0};
        tbl[7]  = '{1, 0, 32'h0,    0,   0,  1, 0, 32'hC,    0,  3,  0};
        tbl[8]  = '{1, 1, 32'hD,    0,   0,  1, 0, 32'hC,    0,  3,  0};
        tbl[9]  = '{1, 1, 32'hE,    0,   0,  1, 1, 32'hD,    1,  3,  0};
        tbl[10] = '{1, 1, 32'hF,    0,   1,  0, 0, 32'hD,    2,  4,  0};
        tbl[11] = '{1, 1, 32'hF,    0,   1,  0, 0, 32'hD,    0,  4,  2};
        tbl[12] = '{1, 0, 32'h0,    0,   0,  1, 0, 32'hD,    0,  4,  2};
        tbl[13] = '{1, 1, 32'h10,   0,   0,  1, 0, 32'hD,    0,  4,  2};
        tbl[14] = '{1, 1, 32'h11,   0,   0,  1, 1, 32'h10,   1,  4,  2};
        tbl[15] = '{0, 0, 32'h0,    0,   1,  0, 0, 32'h10,   2,  5,  2};
        tbl[16] = '{1, 0, 32'h0,    0,   0,  1, 0, 32'h0,    0,  0,  0};

        nRST = 1'b0;
        iv1 = 1'b0; ordy1 = 1'b0; fl1 = 1'b0; din1 = '0;
        iv2 = 1'b0; ordy2 = 1'b0; fl2 = 1'b0; din2 = '0;
        @(negedge CLK);
        step();
        step();

        // Reset state, then push 0xDEADBEEF into the single-entry buffer.
        nRST = 1'b1;
        iv1 = 1'b1; din1 = 32'hDEADBEEF; ordy1 = 1'b1; ordy2 = 1'b1;
        #1;
        chk("rst.out_valid",  32'(ov1),  32'h0);
        chk("rst.out_data",   od1,       32'h0);
        chk("rst.count",      32'(cnt1), 32'h0);
        chk("rst.in_ready1",  32'(ir1),  32'h1);
        chk("rst.in_ready2",  32'(ir2),  32'h1);
        chk("rst.stall_cnt",  32'(stl1), 32'h0);
        chk("rst.squash_cnt", 32'(sqh1), 32'h0);
        step();
        iv1 = 1'b0;
        #1;
        chk("push.out_valid", 32'(ov1),  32'h1);
        chk("push.out_data",  od1,       32'hDEADBEEF);
        chk("push.count",     32'(cnt1), 32'h1);
        step();

        // Back-to-back streaming on both depths with out_ready high.
        for (int i = 1; i <= 8; i++) begin
            iv1 = 1'b1; din1 = 32'(i);
            iv2 = 1'b1; din2 = 32'(i);
            if (i >= 2) begin
                #1;
                chk("stream.d1", od1, 32'(i - 1));
                chk("stream.d2", od2, 32'(i - 1));
            end
            step();
        end
        iv1 = 1'b0; iv2 = 1'b0;
        #1;
        chk("stream.last1", od1, 32'h8);
        chk("stream.last2", od2, 32'h8);
        step();
        chk("stream.stall1", 32'(stl1), 32'h0);
        chk("stream.stall2", 32'(stl2), 32'h0);

        // Skid, flush-with-push and reset-with-flush on the two-entry buffer.
        for (int i = 0; i < 17; i++) begin
            nRST = tbl[i].rn; iv2 = tbl[i].iv; din2 = tbl[i].dat;
            ordy2 = tbl[i].ordy; fl2 = tbl[i].fl;
            #1;
            chk($sformatf("r%0d.in_ready", i),   32'(ir2),  32'(tbl[i].e_ir));
            chk($sformatf("r%0d.out_valid", i),  32'(ov2),  32'(tbl[i].e_ov));
            chk($sformatf("r%0d.out_data", i),   od2,       tbl[i].e_od);
            chk($sformatf("r%0d.count", i),      32'(cnt2), 32'(tbl[i].e_cnt));
            chk($sformatf("r%0d.stall_cnt", i),  32'(stl2), 32'(tbl[i].e_stl));
            chk($sformatf("r%0d.squash_cnt", i), 32'(sqh2), 32'(tbl[i].e_sq));
            step();
        end

        // Stall counter saturation with CNTW=3.
        iv2 = 1'b1; din2 = 32'h55; ordy2 = 1'b0; fl2 = 1'b0;
        step();
        iv2 = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("sat.stall3",  32'(stl3), 32'h7);
        chk("sat.stall2",  32'(stl2), 32'd10);
        step();
        step();
        chk("sat.hold3",   32'(stl3), 32'h7);

        // Random traffic on both depths, with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            nRST  = ($urandom_range(63) != 0);
            iv1   = 1'($urandom_range(1));
            ordy1 = ($urandom_range(3) != 0);
            fl1   = ($urandom_range(15) == 0);
            din1  = $urandom;
            iv2   = ($urandom_range(3) != 0);
            ordy2 = (i < 40) ? 1'(i % 2) : 1'($urandom_range(1));
            fl2   = ($urandom_range(15) == 0);
            din2  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
